// File: rtl/rand_arbiter.sv
// rand_arbiter: round-robin access to one shared 16-bit Fibonacci LFSR.
// Each granted requester receives a value uniformly distributed in [0, limit)
// by rejection sampling, with limit-1 returned once MAX_TRIES draws are spent.
// Optional build macro RAND_ARBITER_FREERUN_EN: the LFSR steps every cycle
// instead of only in STEP, so draws also depend on request timing.
module rand_arbiter #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 7,
  parameter int MAX_TRIES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reseed,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] limit,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      value,
  output logic                  busy
);

  localparam int          PW   = $clog2(NREQ);
  localparam int          TW   = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [15:0] SEED = 16'hBEEF;

  typedef enum logic [1:0] {IDLE, STEP, CHECK, DONE} state_t;

  state_t            state_reg;
  logic [15:0]       lfsr_reg;
  logic [PW-1:0]     ptr_reg;
  logic [PW-1:0]     win_reg;
  logic [WIDTH-1:0]  lim_reg;
  logic [TW-1:0]     tries_reg;

  logic [WIDTH-1:0]  limit_arr [NREQ];
  logic [15:0]       lfsr_next;
  logic [WIDTH-1:0]  draw;
  logic              lfsr_en;
  logic              pick_found;
  logic [PW-1:0]     pick_idx;
  logic              win_req;

  // Split the packed limit bus into one field per requester.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_limit
      assign limit_arr[gi] = limit[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign lfsr_next = {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
  assign draw      = lfsr_reg[WIDTH-1:0];
  assign win_req   = req[win_reg];

`ifdef RAND_ARBITER_FREERUN_EN
  // Free-running: every cycle advances the generator, whatever the state.
  assign lfsr_en = 1'b1;
`else
  // Deterministic: only an un-aborted STEP advances the generator.
  assign lfsr_en = (state_reg == STEP) && win_req;
`endif

  // Round-robin pick: first asserted request at or above ptr, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!pick_found && req[(int'(ptr_reg) + k) % NREQ]) begin
        pick_found = 1'b1;
        pick_idx   = PW'((int'(ptr_reg) + k) % NREQ);
      end
    end
  end

  // LFSR state; a reseed pulse wins over any step in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_reg <= SEED;
    end else if (reseed) begin
      lfsr_reg <= SEED;
    end else if (lfsr_en) begin
      lfsr_reg <= lfsr_next;
    end
  end

  // Arbitration / rejection-sampling FSM with registered gnt, value and busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      win_reg   <= '0;
      lim_reg   <= '0;
      tries_reg <= '0;
      gnt       <= '0;
      value     <= '0;
      busy      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          gnt <= '0;
          if (pick_found) begin
            win_reg   <= pick_idx;
            lim_reg   <= limit_arr[pick_idx];
            tries_reg <= '0;
            state_reg <= STEP;
            busy      <= 1'b1;
          end
        end
        STEP: begin
          if (!win_req) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end else begin
            state_reg <= CHECK;
          end
        end
        CHECK: begin
          if (!win_req) begin
            // Requester withdrew: no grant, pointer left where it was.
            state_reg <= IDLE;
            busy      <= 1'b0;
          end else if ((lim_reg == '0) || (draw < lim_reg)) begin
            value     <= draw;
            gnt       <= NREQ'(1) << win_reg;
            state_reg <= DONE;
          end else if (tries_reg == TW'(MAX_TRIES - 1)) begin
            // Out of attempts: hand back the largest legal value.
            value     <= lim_reg - WIDTH'(1);
            gnt       <= NREQ'(1) << win_reg;
            state_reg <= DONE;
          end else begin
            tries_reg <= tries_reg + TW'(1);
            state_reg <= STEP;
          end
        end
        DONE: begin
          gnt       <= '0;
          ptr_reg   <= (win_reg == PW'(NREQ - 1)) ? '0 : win_reg + PW'(1);
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
          gnt       <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/rand_arbiter.md
# rand_arbiter

Shares one 16-bit Fibonacci LFSR between up to NREQ requesters (puzzle generator, cell shuffler, hint picker) and returns a uniformly distributed value in [0, limit) to each requester through rejection sampling. Round-robin arbitration grants one request at a time. The block owns the LFSR state: same taps (16,14,13,11), same seed 16'hBEEF, and same shift direction as the existing free-running generator. The difference is that here it is step-enabled under FSM control.

## Interface
- NREQ, 4: number of requesters (2..8).
- WIDTH, 7: width of the limit and value fields; WIDTH ≤ 16.
- MAX_TRIES, 16: rejection attempts before the fallback value is used (≥1).

- clk  in  1  system clock.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- reseed  in  1  synchronous one-cycle pulse; reloads the LFSR with 16'hBEEF.
- req  in  NREQ  per-requester level request; held until the matching gnt.
- limit  in  NREQ*WIDTH  per-requester exclusive upper bound; field i = limit[i*WIDTH +: WIDTH]. Must be stable while req[i]=1.
- gnt  out  NREQ  one-hot, one-cycle pulse; value is valid in the same cycle.
- value  out  WIDTH  result; holds its last value until the next grant.
- busy  out  1  high when state ≠ IDLE.

## Operation
- Reset values: lfsr=16'hBEEF, state=IDLE, ptr=0, tries=0, gnt=0, value=0, busy=0.
- LFSR step: lfsr ← {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}. draw = lfsr[WIDTH-1:0].
- **IDLE**:
  - If req≠0, latch the winner, its limit, and tries=0, then go to STEP.
  - Winner = first set bit at or above ptr, wrapping modulo NREQ.
- **STEP**: advance the LFSR, then go to CHECK.
- **CHECK**: evaluate the draw.
  - Accept if limit==0 (full range) or draw < limit. Register value=draw and assert gnt[winner], then go to DONE.
  - On reject with tries < MAX_TRIES-1: tries++, go to STEP.
  - On reject with tries == MAX_TRIES-1: register value=limit-1 (fallback) and assert gnt[winner], then go to DONE.
- **DONE**: gnt returns to 0, ptr=(winner+1) mod NREQ, go to IDLE.
- Winner's req drops while in STEP or CHECK: abort to IDLE at the next edge.
  - No gnt is issued and ptr is unchanged.
  - LFSR steps already taken are kept.
- reseed: loads BEEF and overrides any step in the same cycle. An in-flight draw continues from the new state.
- A requester that keeps req high after its gnt is re-queued behind the other requesters by round-robin.
- rst mid-operation: all state returns to reset values immediately; no gnt is issued.

## Timing
- Latency: req sampled at edge E0 → gnt and value visible after E2, when the first draw is accepted.
- Each rejection adds 2 cycles.
- Maximum latency: 2·MAX_TRIES cycles.
- Minimum grant spacing: 3 cycles (DONE plus IDLE arbitration).
- All outputs are registered; no combinational path from req or limit to gnt or value.

## Configuration
- RAND_ARBITER_FREERUN_EN defined:
  - The LFSR also steps every cycle in IDLE, DONE and CHECK.
  - Draws then depend on request timing, which adds entropy for gameplay.
- Undefined:
  - The LFSR steps only in STEP.
  - The draw sequence is deterministic per grant regardless of idle time.
- All test-plan values below assume the macro is undefined.

## Test plan
- Reset, then req=4'b0001 with limit0=81.
  - Draws 94 (rejected) and 61 (accepted).
  - Required: gnt=4'b0001 and value=61, 4 cycles after req is sampled; busy low the cycle after.
- Reset, then req0 with limit0=100.
  - Required: 94 accepted; gnt after 2 cycles; final lfsr=16'h7DDE.
- MAX_TRIES=2, limit0=1.
  - Draws 94 and 61 are both rejected.
  - Required: gnt0 with fallback value=0 after 4 cycles.
- req=4'b1010 held, ptr=0.
  - Required: gnt=4'b0010 first, then gnt=4'b1000 three or more cycles later, then 4'b0010 again.
- Reseed pulse in CHECK after the first rejection (limit0=81).
  - Required: LFSR reloads to BEEF; next draw is 94 → rejected; next is 61 → accepted.
- rst asserted in STEP.
  - Required: gnt never pulses; value=0; busy=0; lfsr=16'hBEEF immediately.
